dividend_reconstruct_16bit: RTL and testbench
=============================================

DIVIDEND_RECONSTRUCT_16BIT -- requirements
Module: dividend_reconstruct_16bit

Interface
REQ-001 Parameter: WIDTH, 16, operand width; all widths below are in terms of WIDTH.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled on clk only when not busy.
REQ-005 quotient  input  WIDTH  multiplier operand.
REQ-006 divisor  input  WIDTH  multiplicand operand.
REQ-007 remainder  input  WIDTH  addend operand.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  single-cycle pulse when results become valid.
REQ-010 product  output  2*WIDTH  quotient*divisor+remainder, full width.
REQ-011 dividend  output  WIDTH  product[WIDTH-1:0].
REQ-012 overflow  output  1  product[2*WIDTH-1:WIDTH] is nonzero.
REQ-013 rem_invalid  output  1  captured remainder >= captured divisor (covers divisor==0).

Function
REQ-014 FSM states are IDLE, RUN, DONE; reset enters IDLE.
REQ-015 IDLE: start=1 captures all three operands, sets P=zero-extended remainder, MC=zero-extended divisor, MQ=quotient, count=0, and goes to RUN.
REQ-016 RUN: each cycle, if MQ[0]=1 then P=P+MC; MC shifts left 1; MQ shifts right 1; count increments.
REQ-017 RUN lasts exactly WIDTH cycles; after the WIDTH-th step the FSM goes to DONE.
REQ-018 Latency: start sampled at edge N gives done=1 in the cycle after edge N+WIDTH+1, i.e. 17 cycles for WIDTH=16.
REQ-019 DONE lasts one cycle with done=1; it goes to IDLE, or to RUN when start=1, which is accepted exactly as in IDLE.
REQ-020 busy=1 in RUN only; start while busy is ignored with no queuing.
REQ-021 Operand input changes after capture do not affect the running operation.
REQ-022 product, dividend, overflow and rem_invalid update only on entry to DONE; they hold until the next DONE or reset.
REQ-023 P is 2*WIDTH bits and never wraps, because the maximum result (2^WIDTH-1)*2^WIDTH fits.
REQ-024 divisor==0 gives product=remainder and rem_invalid=1; this is not an error stall.
REQ-025 quotient==0 still takes the full WIDTH RUN cycles; there is no early termination.

Reset
REQ-026 rst=1 at any clk edge forces IDLE: busy=0, done=0, product=0, dividend=0, overflow=0, rem_invalid=0, count=0.
REQ-027 rst during RUN aborts the operation; no done is produced; start coincident with rst is ignored.

Structure
REQ-028 Shared package restoring_div_pkg holds WIDTH default, count width clog2(WIDTH+1), and the state enum {IDLE, RUN, DONE}.
REQ-029 The block is a single module with no sub-module; the add-shift step is inline datapath logic.
REQ-030 Outputs are registered, with no combinational path from inputs to outputs.

Verification
REQ-031 q=0x0005, d=0x0003, r=0x0002 -> done 17 cycles after start; product=0x00000011, dividend=0x0011, overflow=0, rem_invalid=0.
REQ-032 q=0xFFFF, d=0xFFFF, r=0xFFFE -> product=0xFFFEFFFF, dividend=0xFFFF, overflow=1, rem_invalid=0.
REQ-033 q=0x1234, d=0x0000, r=0x0007 -> product=0x00000007, overflow=0, rem_invalid=1.
REQ-034 start with q=3, d=4, r=1, then start with q=9, d=9, r=9 at RUN cycle 5 -> single done, product=0x0000000D, busy stays 1 through RUN.
REQ-035 rst at RUN cycle 8 -> next cycle busy=0, done=0, product=0; a following start with q=2, d=7, r=6 gives product=0x00000014.
REQ-036 start held high through DONE -> a new operation starts with no IDLE gap; done pulses every 18 cycles and results are correct each time.

Source files
------------

// File: rtl/restoring_div_pkg.sv
// Shared definitions for the multiply-add dividend reconstruction block:
// default operand width, step-counter sizing and FSM state encoding.
package restoring_div_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  // The counter must reach WIDTH itself, hence WIDTH+1 distinct values.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/dividend_reconstruct_16bit.sv
// Rebuilds dividend = quotient*divisor + remainder with a serial shift-add
// multiplier; flags high-half overflow and an out-of-range remainder.
module dividend_reconstruct_16bit
  import restoring_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   remainder,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   dividend,
  output logic               overflow,
  output logic               rem_invalid
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t             state, state_n;
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] mc;
  logic [WIDTH-1:0]   mq;
  logic [CW-1:0]      cnt;
  logic               rinv_cap;
  logic               load;
  logic               last_step;

  assign load      = start && (state != RUN);
  assign last_step = (cnt == CW'(WIDTH));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last_step) state_n = DONE;
      DONE:    state_n = start ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The WIDTH add-shift steps finish with cnt==WIDTH; the following RUN
  // cycle only publishes P, giving the start-to-done latency of WIDTH+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      p           <= '0;
      mc          <= '0;
      mq          <= '0;
      cnt         <= '0;
      rinv_cap    <= 1'b0;
      product     <= '0;
      overflow    <= 1'b0;
      rem_invalid <= 1'b0;
    end else begin
      state <= state_n;
      if (load) begin
        p        <= {{WIDTH{1'b0}}, remainder};
        mc       <= {{WIDTH{1'b0}}, divisor};
        mq       <= quotient;
        cnt      <= '0;
        rinv_cap <= (remainder >= divisor);
      end else if (state == RUN) begin
        if (!last_step) begin
          if (mq[0]) p <= p + mc;
          mc  <= mc << 1;
          mq  <= mq >> 1;
          cnt <= cnt + 1'b1;
        end else begin
          product     <= p;
          overflow    <= |p[2*WIDTH-1:WIDTH];
          rem_invalid <= rinv_cap;
        end
      end
    end
  end

  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign dividend = product[WIDTH-1:0];

endmodule

// File: tb/tb_dividend_reconstruct_16bit.sv
// Scoreboard bench: stimulus pushes arithmetic expectations, a negedge
// monitor pops them on done and checks values, latency, holding and reset.
module tb_dividend_reconstruct_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] quotient, divisor, remainder;
  logic        busy, done, overflow, rem_invalid;
  logic [31:0] product;
  logic [15:0] dividend;

  dividend_reconstruct_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .busy(busy), .done(done), .product(product), .dividend(dividend),
    .overflow(overflow), .rem_invalid(rem_invalid)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  logic        rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  typedef struct {
    logic [31:0] prod;
    logic        ovf;
    logic        rinv;
    int unsigned due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: reset state, results on done, and holding between dones.
  initial begin : monitor
    exp_t e;
    exp_t last;
    last.prod = '0; last.ovf = 1'b0; last.rinv = 1'b0; last.due = 0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_product", product, 0);
        chk("reset_dividend", dividend, 0);
        chk("reset_overflow", overflow, 0);
        chk("reset_rem_invalid", rem_invalid, 0);
        last.prod = '0; last.ovf = 1'b0; last.rinv = 1'b0;
      end else if (done) begin
        if (exp_q.size() == 0) begin
          chk("spurious_done", done, 0);
        end else begin
          e = exp_q.pop_front();
          chk("latency", cyc, e.due);
          chk("product", product, e.prod);
          chk("dividend", dividend, e.prod[15:0]);
          chk("overflow", overflow, e.ovf);
          chk("rem_invalid", rem_invalid, e.rinv);
          last = e;
        end
      end else begin
        chk("hold_product", product, last.prod);
        chk("hold_flags", {overflow, rem_invalid}, {last.ovf, last.rinv});
      end
    end
  end

  // Caller is at a negedge with the DUT able to accept (IDLE or DONE).
  task automatic do_start(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r,
                          input bit keep, input logic [31:0] p, input bit o, input bit ri);
    exp_t e;
    quotient = q; divisor = d; remainder = r; start = 1'b1;
    @(posedge clk);
    #1;
    e.prod = p; e.ovf = o; e.rinv = ri; e.due = cyc + 17;
    exp_q.push_back(e);
    if (!keep) start = 1'b0;
    quotient  = 16'($urandom);
    divisor   = 16'($urandom);
    remainder = 16'($urandom);
  endtask

  // Reference: plain wide arithmetic on the operands.
  task automatic model_start(input logic [15:0] q, input logic [15:0] d, input logic [15:0] r,
                             input bit keep);
    longint unsigned full;
    full = longint'(q) * longint'(d) + longint'(r);
    do_start(q, d, r, keep, full[31:0], full > 64'hFFFF, r >= d);
  endtask

  task automatic rnd_op(input bit keep);
    logic [15:0] q, d, r;
    q = 16'($urandom); d = 16'($urandom); r = 16'($urandom);
    if ($urandom_range(0, 7) == 0) d = '0;
    if ($urandom_range(0, 7) == 0) q = '0;
    if ($urandom_range(0, 7) == 0) begin q = '1; d = '1; r = '1; end
    model_start(q, d, r, keep);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_timeout", seen, 1);
    if (seen) chk("busy_in_done", busy, 0);
  endtask

  initial begin : stimulus
    rst = 1'b1; start = 1'b0;
    quotient = '0; divisor = '0; remainder = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_start(16'h0005, 16'h0003, 16'h0002, 0, 32'h0000_0011, 0, 0);
    wait_done();
    repeat (2) @(negedge clk);
    do_start(16'hFFFF, 16'hFFFF, 16'hFFFE, 0, 32'hFFFE_FFFF, 1, 0);
    wait_done();
    @(negedge clk);
    do_start(16'h1234, 16'h0000, 16'h0007, 0, 32'h0000_0007, 0, 1);
    wait_done();
    @(negedge clk);
    do_start(16'h0000, 16'h4321, 16'h0100, 0, 32'h0000_0100, 0, 0);
    wait_done();
    @(negedge clk);

    // Start while busy must be ignored, busy stays high throughout RUN.
    do_start(16'd3, 16'd4, 16'd1, 0, 32'h0000_000D, 0, 0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk("busy_in_run", busy, 1);
      if (i == 5) begin
        start = 1'b1; quotient = 16'd9; divisor = 16'd9; remainder = 16'd9;
      end
      if (i == 6) start = 1'b0;
    end
    wait_done();
    @(negedge clk);

    // Reset mid-run with a coincident start aborts without a done.
    rnd_op(0);
    repeat (8) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("abort_busy", busy, 0);
    @(negedge clk);
    do_start(16'd2, 16'd7, 16'd6, 0, 32'h0000_0014, 0, 0);
    wait_done();
    @(negedge clk);

    // Start held high: back-to-back operations every 18 cycles.
    for (int i = 0; i < 4; i++) begin
      rnd_op(1);
      wait_done();
    end
    start = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      rnd_op(0);
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
